// File: rtl/key_debounce_array.sv
// -----------------------------------------------------------------------------
// key_debounce_array
//   Multi-key front end between board pins and control FSMs. Each raw pin is
//   passed through a 2-FF synchroniser, normalised so that 1 = pressed, and
//   debounced by its own small FSM driven by a shared 1 ms tick. Each key
//   produces registered, single-cycle press / release / long-press /
//   auto-repeat pulses. The index of the lowest-numbered key pressed in a
//   cycle is also reported as an encoded key code.
//
// Ports
//   sys_clk       in   1          system clock
//   sys_rst       in   1          asynchronous, active-high reset
//   key_in        in   NUM_KEYS   raw key pins (asynchronous)
//   key_state     out  NUM_KEYS   debounced level, 1 = pressed
//   key_press     out  NUM_KEYS   1-cycle pulse on confirmed press
//   key_release   out  NUM_KEYS   1-cycle pulse on confirmed release
//   key_long      out  NUM_KEYS   1-cycle pulse when the hold reaches LONG_MS
//   key_repeat    out  NUM_KEYS   1-cycle pulse every REPEAT_MS while long-held
//   key_code      out  4          lowest key index with key_press this cycle
//   key_code_vld  out  1          high when any key_press bit is set
// -----------------------------------------------------------------------------
module key_debounce_array #(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_FREQ    = 50_000_000,
  parameter int ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [3:0]          key_code,
  output logic                key_code_vld
);

  localparam int TICK_DIV = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam int MAX_DL   = (DEBOUNCE_MS > LONG_MS) ? DEBOUNCE_MS : LONG_MS;
  localparam int MAX_MS   = (MAX_DL > REPEAT_MS) ? MAX_DL : REPEAT_MS;
  localparam int CW       = $clog2(MAX_MS + 1);

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_MS - 1);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_MS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_MS - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  // Synchronisers come out of reset at the released pin level so that a
  // reset never looks like a key edge.
  localparam logic [NUM_KEYS-1:0] RELEASED_LVL =
    (ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEB_P,
    S_PRESSED,
    S_LONG,
    S_DEB_R
  } state_t;

  // ---------------------------------------------------------------------------
  // Shared 1 ms tick
  // ---------------------------------------------------------------------------
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Synchroniser and polarity normalisation
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] w_raw_p;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync1 <= RELEASED_LVL;
      r_sync2 <= RELEASED_LVL;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw_p = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  // ---------------------------------------------------------------------------
  // Per-key FSM
  // ---------------------------------------------------------------------------
  state_t              r_state    [NUM_KEYS];
  state_t              w_state_nx [NUM_KEYS];
  logic [CW-1:0]       r_cnt      [NUM_KEYS];  // hold / repeat counter
  logic [CW-1:0]       w_cnt_nx   [NUM_KEYS];
  logic [CW-1:0]       r_dcnt     [NUM_KEYS];  // release debounce counter
  logic [CW-1:0]       w_dcnt_nx  [NUM_KEYS];
  logic [NUM_KEYS-1:0] r_was_long;
  logic [NUM_KEYS-1:0] w_was_long_nx;
  logic [NUM_KEYS-1:0] w_press_nx;
  logic [NUM_KEYS-1:0] w_release_nx;
  logic [NUM_KEYS-1:0] w_long_nx;
  logic [NUM_KEYS-1:0] w_repeat_nx;
  logic [NUM_KEYS-1:0] w_level_nx;
  logic [3:0]          w_code_nx;
  logic                w_vld_nx;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // that no path leaves it unassigned, which would infer a latch.
    w_was_long_nx = r_was_long;
    w_press_nx    = '0;
    w_release_nx  = '0;
    w_long_nx     = '0;
    w_repeat_nx   = '0;
    w_level_nx    = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_state_nx[k] = r_state[k];
      w_cnt_nx[k]   = r_cnt[k];
      w_dcnt_nx[k]  = r_dcnt[k];

      // A pin transition takes priority over a coincident tick; that tick is
      // not counted.
      unique case (r_state[k])
        S_IDLE: begin
          if (w_raw_p[k]) begin
            w_state_nx[k] = S_DEB_P;
            w_cnt_nx[k]   = '0;
          end
        end

        S_DEB_P: begin
          if (!w_raw_p[k]) begin
            w_state_nx[k] = S_IDLE;
          end else if (w_tick) begin
            if (r_cnt[k] == DEB_LAST) begin
              w_state_nx[k] = S_PRESSED;
              w_press_nx[k] = 1'b1;
              w_cnt_nx[k]   = '0;
            end else begin
              w_cnt_nx[k] = r_cnt[k] + CNT_ONE;
            end
          end
        end

        S_PRESSED: begin
          if (!w_raw_p[k]) begin
            w_state_nx[k]    = S_DEB_R;
            w_was_long_nx[k] = 1'b0;
            w_dcnt_nx[k]     = '0;
          end else if (w_tick && (LONG_MS != 0)) begin
            if (r_cnt[k] == LONG_LAST) begin
              w_state_nx[k] = S_LONG;
              w_long_nx[k]  = 1'b1;
              w_cnt_nx[k]   = '0;
            end else begin
              w_cnt_nx[k] = r_cnt[k] + CNT_ONE;
            end
          end
        end

        S_LONG: begin
          if (!w_raw_p[k]) begin
            w_state_nx[k]    = S_DEB_R;
            w_was_long_nx[k] = 1'b1;
            w_dcnt_nx[k]     = '0;
          end else if (w_tick && (REPEAT_MS != 0)) begin
            if (r_cnt[k] == REPEAT_LAST) begin
              w_repeat_nx[k] = 1'b1;
              w_cnt_nx[k]    = '0;
            end else begin
              w_cnt_nx[k] = r_cnt[k] + CNT_ONE;
            end
          end
        end

        S_DEB_R: begin
          // r_cnt is left untouched here so a bounce during release resumes
          // the hold/repeat timing where it stopped.
          if (w_raw_p[k]) begin
            w_state_nx[k] = r_was_long[k] ? S_LONG : S_PRESSED;
          end else if (w_tick) begin
            if (r_dcnt[k] == DEB_LAST) begin
              w_state_nx[k]   = S_IDLE;
              w_release_nx[k] = 1'b1;
            end else begin
              w_dcnt_nx[k] = r_dcnt[k] + CNT_ONE;
            end
          end
        end

        default: begin
          w_state_nx[k] = S_IDLE;
        end
      endcase

      w_level_nx[k] = (w_state_nx[k] == S_PRESSED) ||
                      (w_state_nx[k] == S_LONG)    ||
                      (w_state_nx[k] == S_DEB_R);
    end
  end

  // Lowest-numbered pressed key wins; scanning downward lets the last match
  // be the lowest index.
  always_comb begin
    w_code_nx = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (w_press_nx[k]) begin
        w_code_nx = 4'(k);
      end
    end
    w_vld_nx = |w_press_nx;
  end

  // NOTE: the per-key arrays are tiny control state, so they are reset
  // explicitly; every key must come out of reset in IDLE with clean counters.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_state[k] <= S_IDLE;
        r_cnt[k]   <= '0;
        r_dcnt[k]  <= '0;
      end
      r_was_long <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_state[k] <= w_state_nx[k];
        r_cnt[k]   <= w_cnt_nx[k];
        r_dcnt[k]  <= w_dcnt_nx[k];
      end
      r_was_long <= w_was_long_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs: level and event pulses change on the same edge
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] r_key_state;
  logic [NUM_KEYS-1:0] r_key_press;
  logic [NUM_KEYS-1:0] r_key_release;
  logic [NUM_KEYS-1:0] r_key_long;
  logic [NUM_KEYS-1:0] r_key_repeat;
  logic [3:0]          r_key_code;
  logic                r_key_code_vld;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_key_state    <= '0;
      r_key_press    <= '0;
      r_key_release  <= '0;
      r_key_long     <= '0;
      r_key_repeat   <= '0;
      r_key_code     <= '0;
      r_key_code_vld <= 1'b0;
    end else begin
      r_key_state    <= w_level_nx;
      r_key_press    <= w_press_nx;
      r_key_release  <= w_release_nx;
      r_key_long     <= w_long_nx;
      r_key_repeat   <= w_repeat_nx;
      r_key_code     <= w_code_nx;
      r_key_code_vld <= w_vld_nx;
    end
  end

  assign key_state    = r_key_state;
  assign key_press    = r_key_press;
  assign key_release  = r_key_release;
  assign key_long     = r_key_long;
  assign key_repeat   = r_key_repeat;
  assign key_code     = r_key_code;
  assign key_code_vld = r_key_code_vld;

endmodule

// File: tb/tb_key_debounce_array.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_array
//   Directed bench for key_debounce_array. A reduced clock (10 cycles per ms)
//   keeps the long-hold scenario short while all millisecond parameters keep
//   their nominal values. A negedge monitor counts every event pulse and
//   records when it happened; each scenario then compares those records with
//   hand-computed values.
// -----------------------------------------------------------------------------
module tb_key_debounce_array;

  localparam int NK       = 4;
  localparam int CLK_FREQ = 10_000;
  localparam int MS       = CLK_FREQ / 1000;  // clock cycles per millisecond
  localparam int LAT_MIN  = 194;              // press latency window, cycles
  localparam int LAT_MAX  = 204;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [NK-1:0] key_in  = '1;
  logic [NK-1:0] key_state;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;
  logic [NK-1:0] key_repeat;
  logic [3:0]    key_code;
  logic          key_code_vld;

  key_debounce_array #(
    .NUM_KEYS    (NK),
    .CLK_FREQ    (CLK_FREQ),
    .ACTIVE_LOW  (1),
    .DEBOUNCE_MS (20),
    .LONG_MS     (1000),
    .REPEAT_MS   (200)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_in       (key_in),
    .key_state    (key_state),
    .key_press    (key_press),
    .key_release  (key_release),
    .key_long     (key_long),
    .key_repeat   (key_repeat),
    .key_code     (key_code),
    .key_code_vld (key_code_vld)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Event monitor
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  int          n_press [NK];
  int          n_rel   [NK];
  int          n_long  [NK];
  int          n_rep   [NK];
  int          t_press [NK];
  int          t_long  [NK];
  int          t_rep_first [NK];
  int          t_rep_last  [NK];
  int          n_vld    = 0;
  int          code_bad = 0;
  logic [NK-1:0] seen_state = '0;
  logic [NK-1:0] last_vec   = '0;
  logic [3:0]    last_code  = '0;

  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      for (int k = 0; k < NK; k++) begin
        if (key_press[k]) begin
          n_press[k]++;
          t_press[k] = cyc;
        end
        if (key_release[k]) n_rel[k]++;
        if (key_long[k]) begin
          n_long[k]++;
          t_long[k] = cyc;
        end
        if (key_repeat[k]) begin
          if (n_rep[k] == 0) t_rep_first[k] = cyc;
          n_rep[k]++;
          t_rep_last[k] = cyc;
        end
      end
      seen_state = seen_state | key_state;
      if (key_code_vld) begin
        n_vld++;
        last_vec  = key_press;
        last_code = key_code;
      end else if (key_code != 4'd0) begin
        code_bad++;
      end
    end
  end

  task automatic wait_ms(input int n);
    repeat (n * MS) @(negedge sys_clk);
  endtask

  int t_edge;
  int lat;
  int rel_before;

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_state",   key_state, 0);
    check("rst_pulses",  {key_press, key_release, key_long, key_repeat}, 0);
    check("rst_code",    {key_code, key_code_vld}, 0);
    sys_rst = 1'b0;
    wait_ms(5);

    // Bounce on key 0: 5 ms toggles for 40 ms, then held low
    for (int i = 0; i < 8; i++) begin
      key_in[0] = ~key_in[0];
      wait_ms(5);
    end
    key_in[0] = 1'b0;
    t_edge = cyc;
    wait_ms(30);
    lat = t_press[0] - t_edge;
    check("bounce_press_cnt", n_press[0], 1);
    check("bounce_latency_in_window", (lat >= LAT_MIN && lat <= LAT_MAX), 1);
    check("bounce_state", key_state, 4'b0001);
    check("bounce_code", last_code, 0);
    key_in[0] = 1'b1;
    wait_ms(30);
    check("bounce_release_cnt", n_rel[0], 1);
    check("bounce_state_after", key_state, 4'b0000);

    // 10 ms glitch on key 1
    key_in[1] = 1'b0;
    wait_ms(10);
    key_in[1] = 1'b1;
    wait_ms(30);
    check("glitch_press_cnt", n_press[1], 0);
    check("glitch_release_cnt", n_rel[1], 0);
    check("glitch_state_seen", seen_state[1], 0);

    // 100 ms short press on key 2
    key_in[2] = 1'b0;
    wait_ms(100);
    key_in[2] = 1'b1;
    wait_ms(30);
    check("short_press_cnt", n_press[2], 1);
    check("short_release_cnt", n_rel[2], 1);
    check("short_long_cnt", n_long[2], 0);
    check("short_state_seen", seen_state[2], 1);
    check("short_code", last_code, 2);
    check("short_state_after", key_state, 4'b0000);

    // 1500 ms hold on key 1
    key_in[1] = 1'b0;
    wait_ms(1500);
    key_in[1] = 1'b1;
    wait_ms(30);
    check("long_press_cnt", n_press[1], 1);
    check("long_code", last_code, 1);
    check("long_cnt", n_long[1], 1);
    check("long_delay_cyc", t_long[1] - t_press[1], 1000 * MS);
    check("repeat_cnt", n_rep[1], 2);
    check("repeat1_delay_cyc", t_rep_first[1] - t_press[1], 1200 * MS);
    check("repeat2_delay_cyc", t_rep_last[1] - t_press[1], 1400 * MS);
    check("long_release_cnt", n_rel[1], 1);

    // Keys 0 and 3 fall in the same cycle
    key_in = 4'b0110;
    wait_ms(30);
    check("simul_press_vec", last_vec, 4'b1001);
    check("simul_code", last_code, 0);
    check("simul_press0_cnt", n_press[0], 2);
    check("simul_press3_cnt", n_press[3], 1);
    key_in = 4'b1111;
    wait_ms(30);
    check("simul_release0_cnt", n_rel[0], 2);
    check("simul_release3_cnt", n_rel[3], 1);

    // Reset 500 ms into a hold on key 1
    key_in[1] = 1'b0;
    wait_ms(500);
    check("pre_rst_state", key_state, 4'b0010);
    rel_before = n_rel[1];
    sys_rst = 1'b1;
    #1;
    check("mid_rst_state", key_state, 0);
    check("mid_rst_pulses", {key_press, key_release, key_long, key_repeat}, 0);
    check("mid_rst_code", {key_code, key_code_vld}, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    t_edge = cyc;
    wait_ms(30);
    lat = t_press[1] - t_edge;
    check("post_rst_press_cnt", n_press[1], 3);
    check("post_rst_latency_in_window", (lat >= LAT_MIN && lat <= LAT_MAX), 1);
    check("post_rst_no_release", n_rel[1], rel_before);
    check("post_rst_state", key_state, 4'b0010);
    key_in[1] = 1'b1;
    wait_ms(30);
    check("post_rst_release_cnt", n_rel[1], 2);
    check("post_rst_long_cnt", n_long[1], 1);

    // Whole-run bookkeeping
    check("vld_pulse_cnt", n_vld, 6);
    check("code_nonzero_without_vld", code_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
